instr_encoder: RTL and testbench

Pipelined RV32I instruction encoder: packs opcode, register, funct and 32-bit immediate fields into a 32-bit instruction word. It is the inverse of the core's immgen/decoder path and is used by the self-test instruction generator and the boot-ROM patch path. The encoder range-checks each immediate against its format, substitutes a NOP on error, and counts errors. A two-stage valid/ready pipeline sustains one instruction per cycle under backpressure.

---
 rtl/instr_encoder.sv | 103 ++++++++++
 tb/tb_instr_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: two-stage RV32I instruction encoder with immediate range checks and a saturating error count
// Ports: i_clk, i_rst_n (sync active-low); i_valid/o_ready field handshake;
//   i_opcode, i_rd, i_rs1, i_rs2, i_funct3, i_funct7, i_imm instruction fields;
//   o_valid/i_ready word handshake; o_instr encoded word (NOP on error); o_err error flag;
//   o_err_cnt saturating count of errored words handed off.
module instr_encoder (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [6:0]  i_opcode,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_imm,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_instr,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_SH = 3'd2, F_S = 3'd3,
                         F_B = 3'd4, F_U = 3'd5, F_J = 3'd6, F_BAD = 3'd7;
  logic [4:0]  w_op5;
  logic [2:0]  w_fmt;
  logic        w_ok;
  logic        w_s2_adv;
  logic [31:0] w_word;
  logic        r_s1_valid, r_s1_err, r_s2_valid, r_err;
  logic [2:0]  r_fmt, r_f3;
  logic [6:0]  r_op, r_f7;
  logic [4:0]  r_rd, r_rs1, r_rs2;
  logic [31:0] r_imm, r_instr;
  logic [7:0]  r_err_cnt;
  assign w_op5 = i_opcode[6:2];
  always_comb begin
    w_fmt = i_opcode[1:0] != 2'b11 ? F_BAD :
            w_op5 == 5'b01100 ? F_R :
            w_op5 == 5'b00100 ? (i_funct3[1:0] == 2'b01 ? F_SH : F_I) :
            (w_op5 == 5'b00000 || w_op5 == 5'b11001) ? F_I :
            w_op5 == 5'b01000 ? F_S :
            w_op5 == 5'b11000 ? F_B :
            (w_op5 == 5'b01101 || w_op5 == 5'b00101) ? F_U :
            w_op5 == 5'b11011 ? F_J : F_BAD;
    // a signed range check reduces to: every bit above the field's sign bit equals that sign bit
    w_ok = w_fmt == F_R ? 1'b1 :
           (w_fmt == F_I || w_fmt == F_S) ? i_imm[31:11] == {21{i_imm[11]}} :
           w_fmt == F_SH ? i_imm[31:5] == 27'd0 :
           w_fmt == F_B ? (i_imm[31:12] == {20{i_imm[12]}}) && !i_imm[0] :
           w_fmt == F_U ? i_imm[11:0] == 12'd0 :
           w_fmt == F_J ? (i_imm[31:20] == {12{i_imm[20]}}) && !i_imm[0] : 1'b0;
  end
  assign w_s2_adv  = !r_s2_valid | i_ready;
  assign o_ready   = !i_rst_n | !r_s1_valid | w_s2_adv;
  assign o_valid   = r_s2_valid;
  assign o_instr   = r_instr;
  assign o_err     = r_err;
  assign o_err_cnt = r_err_cnt;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (o_ready) begin
      r_s1_valid <= i_valid;
      r_s1_err   <= !w_ok;
      r_fmt      <= w_fmt;
      r_op       <= i_opcode;
      r_rd       <= i_rd;
      r_rs1      <= i_rs1;
      r_rs2      <= i_rs2;
      r_f3       <= i_funct3;
      r_f7       <= i_funct7;
      r_imm      <= i_imm;
    end
  end
  always_comb begin
    w_word = r_fmt == F_R  ? {r_f7, r_rs2, r_rs1, r_f3, r_rd, r_op} :
             r_fmt == F_I  ? {r_imm[11:0], r_rs1, r_f3, r_rd, r_op} :
             r_fmt == F_SH ? {r_f7, r_imm[4:0], r_rs1, r_f3, r_rd, r_op} :
             r_fmt == F_S  ? {r_imm[11:5], r_rs2, r_rs1, r_f3, r_imm[4:0], r_op} :
             r_fmt == F_B  ? {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_f3, r_imm[4:1], r_imm[11], r_op} :
             r_fmt == F_U  ? {r_imm[31:12], r_rd, r_op} :
             r_fmt == F_J  ? {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, r_op} :
             32'h0000_0013;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_instr    <= 32'd0;
      r_err      <= 1'b0;
      r_err_cnt  <= 8'd0;
    end else begin
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        r_instr    <= r_s1_err ? 32'h0000_0013 : w_word;
        r_err      <= r_s1_err;
      end
      if (r_s2_valid && i_ready && r_err && r_err_cnt != 8'hFF)
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder with directed vectors and round-trip decode checks
module tb_instr_encoder;
  logic        i_clk = 1'b0;
  logic        i_rst_n, i_valid, o_ready, o_valid, i_ready, o_err;
  logic [6:0]  i_opcode, i_funct7;
  logic [4:0]  i_rd, i_rs1, i_rs2;
  logic [2:0]  i_funct3;
  logic [31:0] i_imm, o_instr;
  logic [7:0]  o_err_cnt;
  int          n_chk = 0, n_fail = 0;
  bit          rnd_bp = 1'b0;
  typedef struct {
    logic        rt;
    logic [31:0] instr;
    logic        err;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } exp_t;
  exp_t sb[$];
  exp_t dir[22];
  exp_t bp[4];
  exp_t m_e;
  always #5 i_clk = ~i_clk;
  instr_encoder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_funct3(i_funct3), .i_funct7(i_funct7), .i_imm(i_imm),
    .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr), .o_err(o_err),
    .o_err_cnt(o_err_cnt)
  );
  function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic [31:0] instr, input logic err);
    exp_t e;
    e.rt = 1'b0; e.instr = instr; e.err = err; e.op = op; e.rd = rd; e.rs1 = rs1;
    e.rs2 = rs2; e.f3 = f3; e.f7 = f7; e.imm = imm;
    return e;
  endfunction
  function automatic exp_t rnd();
    exp_t e;
    int k;
    e.rt = 1'b1; e.instr = 32'd0; e.err = 1'b0; e.op = 7'h33;
    e.rd = 5'($urandom); e.rs1 = 5'($urandom); e.rs2 = 5'($urandom);
    e.f3 = 3'($urandom); e.f7 = 7'($urandom); e.imm = $urandom;
    k = int'($urandom_range(0, 9));
    case (k)
      1, 2, 3, 4: begin
        e.op = k == 1 ? 7'h13 : k == 2 ? 7'h03 : k == 3 ? 7'h67 : 7'h23;
        if (k == 1 && e.f3[1:0] == 2'b01) e.f3 = 3'd0;
        e.imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      end
      5: begin e.op = 7'h63; e.imm = (32'($urandom_range(0, 4095)) - 32'd2048) << 1; end
      6: begin e.op = 7'h37; e.imm = $urandom & 32'hFFFF_F000; end
      7: begin e.op = 7'h17; e.imm = $urandom & 32'hFFFF_F000; end
      8: begin e.op = 7'h6F; e.imm = (32'($urandom_range(0, 1048575)) - 32'd524288) << 1; end
      9: begin e.op = 7'h13; e.f3 = $urandom_range(0, 1) != 0 ? 3'd1 : 3'd5; e.imm = 32'($urandom_range(0, 31)); end
      default: e.op = 7'h33;
    endcase
    return e;
  endfunction
  function automatic logic rt_ok(input exp_t e, input logic [31:0] w);
    logic ok;
    ok = w[6:0] == e.op;
    case (e.op)
      7'h33: ok = ok && w[31:25] == e.f7 && w[24:20] == e.rs2 && w[19:15] == e.rs1 && w[14:12] == e.f3 && w[11:7] == e.rd;
      7'h13, 7'h03, 7'h67:
        if (e.op == 7'h13 && e.f3[1:0] == 2'b01)
          ok = ok && w[31:25] == e.f7 && {27'd0, w[24:20]} == e.imm && w[19:15] == e.rs1 && w[14:12] == e.f3 && w[11:7] == e.rd;
        else
          ok = ok && {{20{w[31]}}, w[31:20]} == e.imm && w[19:15] == e.rs1 && w[14:12] == e.f3 && w[11:7] == e.rd;
      7'h23: ok = ok && {{20{w[31]}}, w[31:25], w[11:7]} == e.imm && w[24:20] == e.rs2 && w[19:15] == e.rs1 && w[14:12] == e.f3;
      7'h63: ok = ok && {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0} == e.imm && w[24:20] == e.rs2 && w[19:15] == e.rs1 && w[14:12] == e.f3;
      7'h37, 7'h17: ok = ok && {w[31:12], 12'd0} == e.imm && w[11:7] == e.rd;
      7'h6F: ok = ok && {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0} == e.imm && w[11:7] == e.rd;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic send(input exp_t e);
    int t = 0;
    @(negedge i_clk);
    i_opcode = e.op; i_rd = e.rd; i_rs1 = e.rs1; i_rs2 = e.rs2;
    i_funct3 = e.f3; i_funct7 = e.f7; i_imm = e.imm; i_valid = 1'b1;
    #1;
    while (!o_ready && t < 200) begin
      @(negedge i_clk); #1; t++;
    end
    if (!o_ready) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: o_ready %b expected 1", o_ready);
    end else begin
      sb.push_back(e);
      @(posedge i_clk);
    end
    #1 i_valid = 1'b0;
  endtask
  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 1000) begin
      @(negedge i_clk); #3; t++;
    end
    @(posedge i_clk); #1;
    chk("drain_empty", sb.size(), 0);
  endtask
  always @(negedge i_clk) if (rnd_bp) i_ready = $urandom_range(0, 3) != 0;
  always @(negedge i_clk) begin
    #2;
    if (i_rst_n && o_valid && i_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_word: got %h expected no word", o_instr);
      end else begin
        m_e = sb.pop_front();
        if (!m_e.rt && (o_instr !== m_e.instr || o_err !== m_e.err)) begin
          n_fail++;
          $display("FAIL word: got %h err %b expected %h err %b", o_instr, o_err, m_e.instr, m_e.err);
        end else if (m_e.rt && (o_err !== 1'b0 || !rt_ok(m_e, o_instr))) begin
          n_fail++;
          $display("FAIL roundtrip: got %h err %b for op %h rd %0d rs1 %0d rs2 %0d f3 %0d f7 %h imm %h",
                   o_instr, o_err, m_e.op, m_e.rd, m_e.rs1, m_e.rs2, m_e.f3, m_e.f7, m_e.imm);
        end
      end
    end
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    dir[0]  = mk(7'h13, 1, 0, 0, 0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0093, 0);
    dir[1]  = mk(7'h63, 0, 1, 2, 0, 7'h00, 32'h0000_0008, 32'h0020_8463, 0);
    dir[2]  = mk(7'h6F, 1, 0, 0, 0, 7'h00, 32'h0000_0800, 32'h0010_00EF, 0);
    dir[3]  = mk(7'h37, 5, 0, 0, 0, 7'h00, 32'h1234_5000, 32'h1234_52B7, 0);
    dir[4]  = mk(7'h23, 0, 1, 2, 2, 7'h00, 32'hFFFF_FFFC, 32'hFE20_AE23, 0);
    dir[5]  = mk(7'h33, 3, 1, 2, 0, 7'h00, 32'hFFFF_FFFF, 32'h0020_81B3, 0);
    dir[6]  = mk(7'h13, 5, 6, 0, 5, 7'h20, 32'h0000_0003, 32'h4033_5293, 0);
    dir[7]  = mk(7'h13, 1, 0, 0, 0, 7'h00, 32'h0000_07FF, 32'h7FF0_0093, 0);
    dir[8]  = mk(7'h13, 1, 0, 0, 0, 7'h00, 32'hFFFF_F800, 32'h8000_0093, 0);
    dir[9]  = mk(7'h63, 0, 1, 2, 0, 7'h00, 32'h0000_0FFE, 32'h7E20_8FE3, 0);
    dir[10] = mk(7'h6F, 1, 0, 0, 0, 7'h00, 32'hFFF0_0000, 32'h8000_00EF, 0);
    dir[11] = mk(7'h17, 1, 0, 0, 0, 7'h00, 32'h0000_1000, 32'h0000_1097, 0);
    dir[12] = mk(7'h03, 1, 2, 0, 2, 7'h00, 32'h0000_0004, 32'h0041_2083, 0);
    dir[13] = mk(7'h67, 0, 1, 0, 0, 7'h00, 32'h0000_0000, 32'h0000_8067, 0);
    dir[14] = mk(7'h13, 1, 0, 0, 0, 7'h00, 32'h0000_0800, 32'h0000_0013, 1);
    dir[15] = mk(7'h63, 0, 1, 2, 0, 7'h00, 32'h0000_0003, 32'h0000_0013, 1);
    dir[16] = mk(7'h7F, 1, 1, 1, 0, 7'h00, 32'h0000_0000, 32'h0000_0013, 1);
    dir[17] = mk(7'h6F, 1, 0, 0, 0, 7'h00, 32'h0010_0000, 32'h0000_0013, 1);
    dir[18] = mk(7'h37, 5, 0, 0, 0, 7'h00, 32'h1234_5001, 32'h0000_0013, 1);
    dir[19] = mk(7'h13, 1, 1, 0, 1, 7'h00, 32'h0000_0020, 32'h0000_0013, 1);
    dir[20] = mk(7'h31, 1, 1, 1, 0, 7'h00, 32'h0000_0000, 32'h0000_0013, 1);
    dir[21] = mk(7'h63, 0, 1, 2, 0, 7'h00, 32'h0000_1000, 32'h0000_0013, 1);
    bp[0]   = mk(7'h13, 1, 0, 0, 0, 7'h00, 32'd0,  32'h0000_0093, 0);
    bp[1]   = mk(7'h13, 2, 0, 0, 0, 7'h00, 32'd16, 32'h0100_0113, 0);
    bp[2]   = mk(7'h13, 3, 0, 0, 0, 7'h00, 32'd32, 32'h0200_0193, 0);
    bp[3]   = mk(7'h13, 4, 0, 0, 0, 7'h00, 32'd48, 32'h0300_0213, 0);
    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_opcode = 7'd0; i_rd = 5'd0; i_rs1 = 5'd0; i_rs2 = 5'd0;
    i_funct3 = 3'd0; i_funct7 = 7'd0; i_imm = 32'd0;
    #1 chk("ready_in_reset", o_ready, 1);
    repeat (2) @(posedge i_clk);
    @(negedge i_clk); i_rst_n = 1'b1;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_instr", o_instr, 0);
    chk("rst_err", o_err, 0);
    chk("rst_err_cnt", o_err_cnt, 0);
    chk("rst_ready", o_ready, 1);
    send(dir[0]);
    chk("latency_edge1", o_valid, 0);
    @(posedge i_clk); #1;
    chk("latency_edge2", o_valid, 1);
    for (int i = 1; i < 14; i++) send(dir[i]);
    drain();
    chk("err_cnt_legal", o_err_cnt, 0);
    send(dir[14]);
    drain();
    chk("err_cnt_first", o_err_cnt, 1);
    for (int i = 15; i < 22; i++) send(dir[i]);
    drain();
    chk("err_cnt_eight", o_err_cnt, 8);
    for (int i = 0; i < 292; i++) send(dir[16]);
    drain();
    chk("err_cnt_saturate", o_err_cnt, 255);
    i_ready = 1'b0;
    fork
      for (int i = 0; i < 4; i++) send(bp[i]);
      begin
        repeat (3) @(negedge i_clk);
        #2;
        chk("bp_ready_low", o_ready, 0);
        chk("bp_valid", o_valid, 1);
        chk("bp_head", o_instr, 32'h0000_0093);
        repeat (2) begin
          @(negedge i_clk); #2;
          chk("bp_ready_hold", o_ready, 0);
          chk("bp_instr_hold", o_instr, 32'h0000_0093);
          chk("bp_valid_hold", o_valid, 1);
        end
        @(negedge i_clk);
        i_ready = 1'b1;
      end
    join
    drain();
    i_ready = 1'b0;
    send(bp[1]);
    send(bp[2]);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    sb.delete();
    #1 chk("ready_in_midreset", o_ready, 1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("midrst_valid", o_valid, 0);
    chk("midrst_err_cnt", o_err_cnt, 0);
    chk("midrst_ready", o_ready, 1);
    i_ready = 1'b1;
    repeat (6) @(negedge i_clk);
    #3 chk("midrst_no_stale", o_valid, 0);
    rnd_bp = 1'b1;
    for (int i = 0; i < 10000; i++) send(rnd());
    rnd_bp = 1'b0;
    i_ready = 1'b1;
    drain();
    chk("rnd_no_err", o_err_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
